// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MD_BUSY  = 2'd2
    } ctrl_state_e;

    localparam int MC_RD = 0;
    localparam int MC_WR = 1;

    localparam logic [4:0] REG_NOP = 5'd0;

    // Bit order {pc, if_id, id_ex, ex_mem, mem_wb}
    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } wr_en_t;

    // Bit order {if_id, id_ex, ex_mem}
    typedef struct packed {
        logic if_id;
        logic id_ex;
        logic ex_mem;
    } flush_t;

    localparam wr_en_t EN_ALL  = 5'b11111;
    localparam wr_en_t EN_NONE = 5'b00000;
    localparam wr_en_t EN_MD   = 5'b00011;
    localparam wr_en_t EN_LU   = 5'b00111;

    localparam flush_t FL_NONE = 3'b000;
    localparam flush_t FL_ALL  = 3'b111;
    localparam flush_t FL_BR   = 3'b110;
    localparam flush_t FL_LU   = 3'b010;
    localparam flush_t FL_MD   = 3'b001;

    // A load in EX whose destination feeds the instruction in ID; r0 never hazards.
    function automatic logic load_use_hazard(
        input logic       mem_read,
        input logic [4:0] rw,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rt
    );
        return mem_read && (rw != REG_NOP) && ((rw == rs) || (use_rt && (rw == rt)));
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and stage-control outputs between the pipeline datapath and
// the stall controller; master is the controller, slave is the datapath.
interface pipeline_stall_ctrl_if;
    logic [4:0] rsId;
    logic [4:0] rtId;
    logic       useRtId;
    logic       memReadEx;
    logic [4:0] rWEx;
    logic       mdStartEx;
    logic       branchTakenEx;
    logic [4:0] memCtrlMem;
    logic       memReady;
    logic       memReq;
    logic       pcWrite;
    logic       ifIdWrite;
    logic       idExWrite;
    logic       exMemWrite;
    logic       memWbWrite;
    logic       ifIdFlush;
    logic       idExFlush;
    logic       exMemFlush;
    logic       memError;

    modport master (
        input  rsId, rtId, useRtId, memReadEx, rWEx, mdStartEx, branchTakenEx,
               memCtrlMem, memReady,
        output memReq, pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite,
               ifIdFlush, idExFlush, exMemFlush, memError
    );

    modport slave (
        output rsId, rtId, useRtId, memReadEx, rWEx, mdStartEx, branchTakenEx,
               memCtrlMem, memReady,
        input  memReq, pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite,
               ifIdFlush, idExFlush, exMemFlush, memError
    );
endinterface

// File: rtl/pipeline_stall_ctrl_stall_counter.sv
// Loadable up/down counter shared by the memory-wait and mul/div stall paths.
module stall_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    input  logic [CNT_W-1:0] match_val,
    output logic             zero,
    output logic             match
);
    logic [CNT_W-1:0] cnt_r;

    // Count register: load beats inc beats dec
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (inc) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else if (dec) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero  = (cnt_r == '0);
    assign match = (cnt_r == match_val);
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use stalls, branch
// flushes, mul/div occupancy of EX and data-memory wait with timeout.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter int MEM_TIMEOUT   = 16,
    parameter int CNT_W         = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_stall_ctrl_if.master bus
);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MD_LOAD = CNT_W'(MULDIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(MEM_TIMEOUT);

    ctrl_state_e      state_r;
    ctrl_state_e      state_next_s;
    logic             md_done_r;
    logic             mem_error_r;
    logic             err_set_s;
    logic             mem_acc_s;
    logic             load_use_s;
    wr_en_t           adv_en_s;
    flush_t           adv_fl_s;
    logic             adv_md_s;
    wr_en_t           en_s;
    flush_t           fl_s;
    wr_en_t           out_en_s;
    flush_t           out_fl_s;
    logic             cnt_load_s;
    logic             cnt_inc_s;
    logic             cnt_dec_s;
    logic             cnt_zero_s;
    logic             cnt_match_s;
    logic [CNT_W-1:0] cnt_load_val_s;
    logic [CNT_W-1:0] cnt_match_val_s;

    assign mem_acc_s  = bus.memCtrlMem[MC_RD] | bus.memCtrlMem[MC_WR];
    assign load_use_s = load_use_hazard(bus.memReadEx, bus.rWEx, bus.rsId,
                                        bus.rtId, bus.useRtId);
    assign cnt_match_val_s = (state_r == MD_BUSY) ? CNT_ONE : CNT_TIMEOUT;

    // Hazard response for a cycle in which EX is free to advance; the
    // instruction that just finished its mul/div stall must not restart it.
    always_comb begin
        adv_en_s = EN_ALL;
        adv_fl_s = FL_NONE;
        adv_md_s = 1'b0;
        if (bus.mdStartEx && !md_done_r) begin
            adv_md_s = 1'b1;
            adv_en_s = EN_MD;
            adv_fl_s = FL_MD;
        end else if (bus.branchTakenEx) begin
            adv_en_s = EN_ALL;
            adv_fl_s = FL_BR;
        end else if (load_use_s) begin
            adv_en_s = EN_LU;
            adv_fl_s = FL_LU;
        end else begin
            adv_en_s = EN_ALL;
            adv_fl_s = FL_NONE;
        end
    end

    // Next-state, counter control and stage enables
    always_comb begin
        state_next_s   = state_r;
        en_s           = EN_ALL;
        fl_s           = FL_NONE;
        err_set_s      = 1'b0;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = CNT_ONE;
        cnt_inc_s      = 1'b0;
        cnt_dec_s      = 1'b0;
        case (state_r)
            RUN: begin
                if (mem_acc_s && !bus.memReady) begin
                    en_s           = EN_NONE;
                    state_next_s   = MEM_WAIT;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = CNT_ONE;
                end else begin
                    en_s = adv_en_s;
                    fl_s = adv_fl_s;
                    if (adv_md_s) begin
                        state_next_s   = MD_BUSY;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = CNT_MD_LOAD;
                    end else begin
                        state_next_s = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                // Release cycle (ready or timeout) replays whatever EX holds
                if (bus.memReady || cnt_match_s) begin
                    err_set_s = !bus.memReady;
                    en_s      = adv_en_s;
                    fl_s      = adv_fl_s;
                    if (adv_md_s) begin
                        state_next_s   = MD_BUSY;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = CNT_MD_LOAD;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    en_s      = EN_NONE;
                    cnt_inc_s = 1'b1;
                end
            end
            MD_BUSY: begin
                en_s      = EN_MD;
                fl_s      = FL_MD;
                cnt_dec_s = 1'b1;
                // Zero is only reachable if the count was disturbed; leave rather than lock up
                if (cnt_match_s || cnt_zero_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = MD_BUSY;
                end
            end
            default: begin
                state_next_s = RUN;
                en_s         = EN_ALL;
                fl_s         = FL_ALL;
            end
        endcase
    end

    // While reset is held, every stage loads a NOP so the pipeline drains
    assign out_en_s = reset ? EN_ALL : en_s;
    assign out_fl_s = reset ? FL_ALL : fl_s;

    assign bus.memReq     = mem_acc_s && (state_r != MD_BUSY);
    assign bus.pcWrite    = out_en_s.pc;
    assign bus.ifIdWrite  = out_en_s.if_id;
    assign bus.idExWrite  = out_en_s.id_ex;
    assign bus.exMemWrite = out_en_s.ex_mem;
    assign bus.memWbWrite = out_en_s.mem_wb;
    assign bus.ifIdFlush  = out_fl_s.if_id;
    assign bus.idExFlush  = out_fl_s.id_ex;
    assign bus.exMemFlush = out_fl_s.ex_mem;
    assign bus.memError   = mem_error_r;

    // State, mul/div completion marker and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= RUN;
            md_done_r   <= 1'b0;
            mem_error_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            md_done_r   <= (state_r == MD_BUSY) && (state_next_s == RUN);
            mem_error_r <= mem_error_r | err_set_s;
        end
    end

    stall_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load_s),
        .load_val  (cnt_load_val_s),
        .inc       (cnt_inc_s),
        .dec       (cnt_dec_s),
        .match_val (cnt_match_val_s),
        .zero      (cnt_zero_s),
        .match     (cnt_match_s)
    );
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: vector table, directed multi-cycle sequences
// and randomized traffic against a cycle-level reference model.
module tb_pipeline_stall_ctrl;
    localparam int MDC = 4;
    localparam int MTO = 16;

    localparam logic [4:0] EN1  = 5'b11111;
    localparam logic [4:0] EN0  = 5'b00000;
    localparam logic [4:0] ENMD = 5'b00011;
    localparam logic [4:0] ENLU = 5'b00111;
    localparam logic [2:0] FL0  = 3'b000;
    localparam logic [2:0] FL1  = 3'b111;
    localparam logic [2:0] FLBR = 3'b110;
    localparam logic [2:0] FLLU = 3'b010;
    localparam logic [2:0] FLMD = 3'b001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipeline_stall_ctrl_if ifc ();

    pipeline_stall_ctrl #(
        .MULDIV_CYCLES (MDC),
        .MEM_TIMEOUT   (MTO),
        .CNT_W         (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0] rs, rt;
        logic       urt, mr;
        logic [4:0] rw;
        logic       br;
        logic [4:0] mc;
        logic       rdy;
        logic       req;
        logic [4:0] en;
        logic [2:0] fl;
    } vec_t;

    vec_t tbl [9];

    // {memReq, pc, ifId, idEx, exMem, memWb, ifIdFl, idExFl, exMemFl, memError}
    function automatic logic [9:0] exp_v(logic req, logic [4:0] en, logic [2:0] fl, logic err);
        return {req, en, fl, err};
    endfunction

    function automatic logic [9:0] act_v();
        return {ifc.memReq, ifc.pcWrite, ifc.ifIdWrite, ifc.idExWrite, ifc.exMemWrite,
                ifc.memWbWrite, ifc.ifIdFlush, ifc.idExFlush, ifc.exMemFlush, ifc.memError};
    endfunction

    task automatic check(string name, logic [9:0] exp);
        logic [9:0] act;
        act = act_v();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (req,en5,fl3,err)", name, act, exp);
        end
    endtask

    task automatic set_in(logic [4:0] rs, logic [4:0] rt, logic urt, logic mr, logic [4:0] rw,
                          logic md, logic br, logic [4:0] mc, logic rdy);
        ifc.rsId = rs; ifc.rtId = rt; ifc.useRtId = urt; ifc.memReadEx = mr; ifc.rWEx = rw;
        ifc.mdStartEx = md; ifc.branchTakenEx = br; ifc.memCtrlMem = mc; ifc.memReady = rdy;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    // Check on the falling edge, then step past the next rising edge
    task automatic probe(string name, logic [9:0] exp);
        @(negedge clk);
        check(name, exp);
        @(posedge clk);
        #1;
    endtask

    bit         m_wait, m_mddone, m_err;
    int         m_wcnt, m_mdleft;
    logic [4:0] r_rs, r_rt, r_rw, r_mc;
    logic       r_rst, r_urt, r_mr, r_md, r_br, r_rdy, acc, lu, rel;
    logic [9:0] e;

    initial begin
        tbl[0] = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd1, 1'b0, 5'd0,  1'b0, 1'b0, EN1,  FL0};
        tbl[1] = '{5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0,  1'b0, 1'b0, ENLU, FLLU};
        tbl[2] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, EN1,  FL0};
        tbl[3] = '{5'd2, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0,  1'b0, 1'b0, ENLU, FLLU};
        tbl[4] = '{5'd2, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0,  1'b0, 1'b0, EN1,  FL0};
        tbl[5] = '{5'd4, 5'd5, 1'b1, 1'b0, 5'd6, 1'b1, 5'd0,  1'b0, 1'b0, EN1,  FLBR};
        tbl[6] = '{5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b1, 5'd0,  1'b0, 1'b0, EN1,  FLBR};
        tbl[7] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 5'd2,  1'b1, 1'b1, EN1,  FL0};
        tbl[8] = '{5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b0, 5'd1,  1'b1, 1'b1, ENLU, FLLU};

        idle();
        reset = 1'b1;
        probe("reset_outs", exp_v(1'b0, EN1, FL1, 1'b0));
        reset = 1'b0;
        probe("post_reset_idle", exp_v(1'b0, EN1, FL0, 1'b0));

        foreach (tbl[i]) begin
            set_in(tbl[i].rs, tbl[i].rt, tbl[i].urt, tbl[i].mr, tbl[i].rw, 1'b0,
                   tbl[i].br, tbl[i].mc, tbl[i].rdy);
            probe($sformatf("vec%0d", i), exp_v(tbl[i].req, tbl[i].en, tbl[i].fl, 1'b0));
        end

        // Memory wait: 3 not-ready cycles then ready
        idle(); ifc.memCtrlMem = 5'b00001;
        for (int k = 0; k < 3; k++) probe($sformatf("memwait_stall%0d", k), exp_v(1'b1, EN0, FL0, 1'b0));
        ifc.memReady = 1'b1;
        probe("memwait_ready", exp_v(1'b1, EN1, FL0, 1'b0));
        idle();
        probe("memwait_after", exp_v(1'b0, EN1, FL0, 1'b0));

        // Mul/div held in EX: four frozen cycles, fifth advances
        idle(); ifc.mdStartEx = 1'b1;
        for (int k = 0; k < MDC; k++) probe($sformatf("md_stall%0d", k), exp_v(1'b0, ENMD, FLMD, 1'b0));
        probe("md_release", exp_v(1'b0, EN1, FL0, 1'b0));
        idle();
        probe("md_after", exp_v(1'b0, EN1, FL0, 1'b0));

        // mdStartEx during memory wait: mul/div stall starts on the ready cycle
        idle(); ifc.memCtrlMem = 5'b00001; ifc.mdStartEx = 1'b1;
        for (int k = 0; k < 2; k++) probe($sformatf("mdmw_stall%0d", k), exp_v(1'b1, EN0, FL0, 1'b0));
        ifc.memReady = 1'b1;
        probe("mdmw_ready", exp_v(1'b1, ENMD, FLMD, 1'b0));
        ifc.memCtrlMem = 5'd0; ifc.memReady = 1'b0;
        for (int k = 1; k < MDC; k++) probe($sformatf("mdmw_busy%0d", k), exp_v(1'b0, ENMD, FLMD, 1'b0));
        probe("mdmw_release", exp_v(1'b0, EN1, FL0, 1'b0));

        // Branch co-issued with mul/div: flush lands when EX advances
        idle(); ifc.mdStartEx = 1'b1; ifc.branchTakenEx = 1'b1;
        for (int k = 0; k < MDC; k++) probe($sformatf("mdbr_stall%0d", k), exp_v(1'b0, ENMD, FLMD, 1'b0));
        probe("mdbr_flush", exp_v(1'b0, EN1, FLBR, 1'b0));

        // Reset during MD_BUSY
        idle(); ifc.mdStartEx = 1'b1;
        for (int k = 0; k < 2; k++) probe($sformatf("mdrst_stall%0d", k), exp_v(1'b0, ENMD, FLMD, 1'b0));
        reset = 1'b1;
        probe("mdrst_reset", exp_v(1'b0, EN1, FL1, 1'b0));
        reset = 1'b0; idle();
        probe("mdrst_run", exp_v(1'b0, EN1, FL0, 1'b0));

        // Timeout: 16 stall cycles, forced release, sticky error
        idle(); ifc.memCtrlMem = 5'b00010;
        for (int k = 0; k < MTO; k++) probe($sformatf("to_stall%0d", k), exp_v(1'b1, EN0, FL0, 1'b0));
        probe("to_release", exp_v(1'b1, EN1, FL0, 1'b0));
        idle();
        for (int k = 0; k < 3; k++) probe($sformatf("to_sticky%0d", k), exp_v(1'b0, EN1, FL0, 1'b1));
        ifc.memCtrlMem = 5'b00001;
        probe("to_sticky_stall", exp_v(1'b1, EN0, FL0, 1'b1));
        ifc.memReady = 1'b1;
        probe("to_sticky_ready", exp_v(1'b1, EN1, FL0, 1'b1));
        idle(); reset = 1'b1;
        probe("to_reset", exp_v(1'b0, EN1, FL1, 1'b1));
        reset = 1'b0;
        probe("to_cleared", exp_v(1'b0, EN1, FL0, 1'b0));

        // Randomized traffic against the reference model
        m_wait = 1'b0; m_mddone = 1'b0; m_err = 1'b0; m_wcnt = 0; m_mdleft = 0;
        for (int i = 0; i < 3000; i++) begin
            r_rst = (i == 0) || ($urandom_range(0, 63) == 0);
            r_rs  = 5'($urandom_range(0, 3));
            r_rt  = 5'($urandom_range(0, 3));
            r_rw  = 5'($urandom_range(0, 3));
            r_urt = 1'($urandom_range(0, 1));
            r_mr  = 1'($urandom_range(0, 1));
            r_md  = ($urandom_range(0, 15) == 0);
            r_br  = ($urandom_range(0, 7) == 0);
            r_mc  = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31))
                                                : (5'($urandom_range(0, 31)) & 5'b11100);
            r_rdy = ($urandom_range(0, 9) < 3);
            reset = r_rst;
            set_in(r_rs, r_rt, r_urt, r_mr, r_rw, r_md, r_br, r_mc, r_rdy);

            acc = r_mc[0] | r_mc[1];
            lu  = r_mr && (r_rw != 5'd0) && ((r_rw == r_rs) || (r_urt && (r_rw == r_rt)));
            if (r_rst) begin
                e = exp_v(acc && (m_mdleft == 0), EN1, FL1, m_err);
                m_wait = 1'b0; m_wcnt = 0; m_mdleft = 0; m_mddone = 1'b0; m_err = 1'b0;
            end else if (m_mdleft > 0) begin
                e = exp_v(1'b0, ENMD, FLMD, m_err);
                m_mdleft--;
                m_mddone = (m_mdleft == 0);
            end else begin
                rel = m_wait && (r_rdy || (m_wcnt == MTO));
                if ((!m_wait && acc && !r_rdy) || (m_wait && !rel)) begin
                    e = exp_v(acc, EN0, FL0, m_err);
                    if (m_wait) m_wcnt++;
                    else begin m_wait = 1'b1; m_wcnt = 1; end
                end else begin
                    if (r_md && !m_mddone) begin
                        e = exp_v(acc, ENMD, FLMD, m_err);
                        m_mdleft = MDC - 1;
                    end else if (r_br) e = exp_v(acc, EN1, FLBR, m_err);
                    else if (lu)       e = exp_v(acc, ENLU, FLLU, m_err);
                    else               e = exp_v(acc, EN1, FL0, m_err);
                    if (rel && !r_rdy) m_err = 1'b1;
                    m_wait = 1'b0;
                end
                m_mddone = 1'b0;
            end
            probe($sformatf("rand%0d", i), e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
